// File: rtl/add16_arb_pkg.sv
// ============================================================================
//  Module      : add16_arb_pkg
//  Description : Shared types and constants for the add16_arb block.
//                Holds the FSM state enum, the datapath width and the
//                default number of requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add16_arb_pkg;

    // Datapath width of the shared adder
    localparam int c_DATA_W   = 16;

    // Default number of requesters sharing the adder
    localparam int c_NREQ_DEF = 4;

    // Transaction FSM: one transaction in flight at a time
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : add16_arb_pkg

`default_nettype wire

// File: rtl/add16_arb_add16.sv
// ============================================================================
//  Module      : add16_arb_add16
//  Description : ADD16 - plain 16-bit adder, carry-out discarded.
//  Ports       : X, Y - operands
//                s    - (X + Y) mod 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add16_arb_add16
    import add16_arb_pkg::*;
(
    input  logic [c_DATA_W-1:0] X,
    input  logic [c_DATA_W-1:0] Y,
    output logic [c_DATA_W-1:0] s
);

    assign s = X + Y;

endmodule : add16_arb_add16

`default_nettype wire

// File: rtl/add16_arb.sv
// ============================================================================
//  Module      : add16_arb
//  Description : Round-robin arbiter sharing one ADD16 among NREQ requesters.
//                IDLE grants one requester (combinational one-hot gnt) and
//                latches its operands, CALC registers the sum, RESP holds the
//                result until rsp_ready.
//  Parameters  : NREQ (2..8) - number of requesters
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                req[NREQ]             - per-requester request level
//                a_in/b_in[NREQ*16]    - packed operands, requester i at [16*i +: 16]
//                gnt[NREQ]             - one-cycle one-hot acceptance
//                rsp_valid/rsp_ready   - result handshake
//                rsp_sum, rsp_id       - registered sum and owning requester
//                rsp_ovf               - signed overflow (only with ADD16_ARB_OVF_EN)
//  Options     : define ADD16_ARB_OVF_EN to add the rsp_ovf port and logic
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add16_arb
    import add16_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*c_DATA_W-1:0]   a_in,
    input  logic [NREQ*c_DATA_W-1:0]   b_in,
    output logic [NREQ-1:0]            gnt,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [c_DATA_W-1:0]        rsp_sum,
    output logic [$clog2(NREQ)-1:0]    rsp_id
`ifdef ADD16_ARB_OVF_EN
    ,
    output logic                       rsp_ovf
`endif
);

    localparam int c_ID_W = $clog2(NREQ);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_DATA_W-1:0] r_op_a;
    logic [c_DATA_W-1:0] r_op_b;
    logic [c_ID_W-1:0]   r_op_id;
    logic [c_DATA_W-1:0] r_rsp_sum;
    logic [c_ID_W-1:0]   r_rsp_id;
    logic [c_DATA_W-1:0] w_sum;
    logic [c_ID_W-1:0]   w_winner;
    logic [c_ID_W-1:0]   w_idx;
    logic                w_found;
    logic [NREQ-1:0]     w_gnt;

    // ------------------------------------------------------------------
    // Round-robin search: first set request at or after r_rr_ptr,
    // wrapping modulo NREQ (NREQ need not be a power of two).
    // ------------------------------------------------------------------
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = c_ID_W'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and grant decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt[w_winner] = 1'b1;
                    w_state_nxt     = CALC;
                end
            end
            CALC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                // No grant in the release cycle; arbitration resumes in IDLE
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant is suppressed while reset is asserted
    assign gnt = rst ? '0 : w_gnt;

    // ------------------------------------------------------------------
    // Shared adder
    // ------------------------------------------------------------------
    add16_arb_add16 u_add16 (
        .X (r_op_a),
        .Y (r_op_b),
        .s (w_sum)
    );

`ifdef ADD16_ARB_OVF_EN
    logic r_rsp_ovf;
`endif

    // ------------------------------------------------------------------
    // Operand capture, result registers and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_id   <= '0;
            r_rsp_sum <= '0;
            r_rsp_id  <= '0;
`ifdef ADD16_ARB_OVF_EN
            r_rsp_ovf <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_op_a  <= a_in[int'(w_winner)*c_DATA_W +: c_DATA_W];
                        r_op_b  <= b_in[int'(w_winner)*c_DATA_W +: c_DATA_W];
                        r_op_id <= w_winner;
                    end
                end
                CALC: begin
                    r_rsp_sum <= w_sum;
                    r_rsp_id  <= r_op_id;
`ifdef ADD16_ARB_OVF_EN
                    // Same-sign operands producing an opposite-sign result
                    r_rsp_ovf <= (r_op_a[c_DATA_W-1] == r_op_b[c_DATA_W-1]) &&
                                 (w_sum[c_DATA_W-1] != r_op_a[c_DATA_W-1]);
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        // Winner becomes lowest priority for the next round
                        if (r_op_id == c_ID_W'(NREQ - 1)) begin
                            r_rr_ptr <= '0;
                        end else begin
                            r_rr_ptr <= r_op_id + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
`ifdef ADD16_ARB_OVF_EN
    assign rsp_ovf   = r_rsp_ovf;
`endif

endmodule : add16_arb

`default_nettype wire

// File: tb/tb_add16_arb.sv
// ============================================================================
//  Module      : tb_add16_arb
//  Description : Self-checking bench for add16_arb (NREQ = 4). Expected
//                grants, sums and overflow come from a round-robin /
//                integer-arithmetic reference model kept in the bench.
//  Options     : honours ADD16_ARB_OVF_EN for the rsp_ovf port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add16_arb;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_sum;
    logic [1:0]  rsp_id;
    logic        rsp_ovf;

    int          nerr = 0;
    int          nchk = 0;
    int          m_ptr = 0;
    logic [15:0] a_op [4];
    logic [15:0] b_op [4];

    always #5 clk = ~clk;

    add16_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef ADD16_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

`ifndef ADD16_ARB_OVF_EN
    assign rsp_ovf = 1'b0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    task automatic load_ops();
        for (int i = 0; i < 4; i++) begin
            a_in[i*16 +: 16] = a_op[i];
            b_in[i*16 +: 16] = b_op[i];
        end
    endtask

    // Reference round-robin choice: first requester at or after ptr
    function automatic int model_winner(input logic [3:0] r, input int ptr);
        logic [1:0] j;
        for (int k = 0; k < 4; k++) begin
            j = 2'((ptr + k) % 4);
            if (r[j]) return int'(j);
        end
        return -1;
    endfunction

    // One full transaction, entered and left just after a falling edge in IDLE.
    task automatic run_txn(input logic [3:0] rq, input logic [3:0] rq_after,
                           input int stall, output logic [3:0] g,
                           output logic [15:0] sum, output logic [1:0] id,
                           output logic ovf);
        int          exp_w;
        int          waited;
        int          s_int;
        logic [15:0] exp_sum;
        logic        exp_ovf;
        logic [3:0]  exp_g;
        g = '0; sum = '0; id = '0; ovf = 1'b0;
        req = rq;
        load_ops();
        #1;
        exp_w  = model_winner(rq, m_ptr);
        exp_g  = 4'b0001 << exp_w;
        waited = 0;
        while (gnt == 4'b0000 && waited < 8) begin
            @(negedge clk); #1;
            waited++;
        end
        nchk++;
        if (gnt !== exp_g) begin
            nerr++;
            $display("FAIL txn_gnt: got %b expected %b (ptr=%0d req=%b)", gnt, exp_g, m_ptr, rq);
        end
        if (gnt == 4'b0000) begin
            req = 4'b0000;
            return;
        end
        g       = gnt;
        exp_sum = a_op[exp_w] + b_op[exp_w];
        s_int   = int'($signed(a_op[exp_w])) + int'($signed(b_op[exp_w]));
        exp_ovf = (s_int > 32767) || (s_int < -32768);

        @(negedge clk);
        req = rq_after;
        #1;
        nchk++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
            nerr++;
            $display("FAIL txn_calc: rsp_valid=%b gnt=%b expected 0 and 0000", rsp_valid, gnt);
        end

        @(negedge clk); #1;
        nchk++;
        if (rsp_valid !== 1'b1) begin
            nerr++;
            $display("FAIL txn_latency: rsp_valid=%b at grant+2 expected 1", rsp_valid);
        end
        sum = rsp_sum; id = rsp_id; ovf = rsp_ovf;
        nchk++;
        if (rsp_sum !== exp_sum || rsp_id !== 2'(exp_w)) begin
            nerr++;
            $display("FAIL txn_result: sum=%h id=%0d expected sum=%h id=%0d", rsp_sum, rsp_id, exp_sum, exp_w);
        end
`ifdef ADD16_ARB_OVF_EN
        nchk++;
        if (rsp_ovf !== exp_ovf) begin
            nerr++;
            $display("FAIL txn_ovf: got %b expected %b", rsp_ovf, exp_ovf);
        end
`endif

        for (int k = 0; k < stall; k++) begin
            @(negedge clk); #1;
            nchk++;
            if (rsp_valid !== 1'b1 || rsp_sum !== sum || rsp_id !== id || rsp_ovf !== ovf || gnt !== 4'b0000) begin
                nerr++;
                $display("FAIL txn_hold: valid=%b sum=%h id=%0d gnt=%b expected 1 %h %0d 0000", rsp_valid, rsp_sum, rsp_id, gnt, sum, id);
            end
        end

        rsp_ready = 1'b1;
        #1;
        nchk++;
        if (gnt !== 4'b0000) begin
            nerr++;
            $display("FAIL txn_release_gnt: gnt=%b expected 0000", gnt);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        nchk++;
        if (rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL txn_idle: rsp_valid=%b expected 0", rsp_valid);
        end
        m_ptr = (exp_w + 1) % 4;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; rsp_ready = 1'b0;
        a_in = '0; b_in = '0;
        @(negedge clk); #1;
        nchk++;
        if (gnt !== 4'b0000 || rsp_valid !== 1'b0 || rsp_sum !== 16'h0 || rsp_id !== 2'd0 || rsp_ovf !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: gnt=%b valid=%b sum=%h id=%0d ovf=%b expected all zero", gnt, rsp_valid, rsp_sum, rsp_id, rsp_ovf);
        end
        @(negedge clk);
        rst = 1'b0; req = 4'b0000;
        #1;
        nchk++;
        if (gnt !== 4'b0000 || rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_idle: gnt=%b valid=%b expected 0000 0", gnt, rsp_valid);
        end
        m_ptr = 0;
    endtask

    task automatic test_single();
        logic [3:0] g; logic [15:0] s; logic [1:0] id; logic ov;
        a_op[0] = 16'h0003; b_op[0] = 16'h0004;
        run_txn(4'b0001, 4'b0000, 0, g, s, id, ov);
        nchk++;
        if (g !== 4'b0001 || s !== 16'h0007 || id !== 2'd0) begin
            nerr++;
            $display("FAIL single: gnt=%b sum=%h id=%0d expected 0001 0007 0", g, s, id);
        end
    endtask

    task automatic test_contention();
        logic [3:0] g; logic [15:0] s; logic [1:0] id; logic ov;
        int order [5] = '{0, 1, 2, 3, 0};
        m_ptr = 0;
        // Bring the pointer back to 0 by completing a grant on requester 3
        run_txn(4'b1000, 4'b0000, 0, g, s, id, ov);
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 4; i++) begin
                a_op[i] = 16'($urandom); b_op[i] = 16'($urandom);
            end
            run_txn(4'b1111, 4'b1111, 0, g, s, id, ov);
            nchk++;
            if (g !== (4'b0001 << order[t]) || id !== 2'(order[t])) begin
                nerr++;
                $display("FAIL contention_order: step %0d gnt=%b id=%0d expected requester %0d", t, g, id, order[t]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [3:0] g; logic [15:0] s; logic [1:0] id; logic ov;
        a_op[1] = 16'hFFFF; b_op[1] = 16'h0001;
        run_txn(4'b0010, 4'b0000, 0, g, s, id, ov);
        nchk++;
        if (s !== 16'h0000 || ov !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_ffff: sum=%h ovf=%b expected 0000 0", s, ov);
        end
        a_op[1] = 16'h7FFF; b_op[1] = 16'h0001;
        run_txn(4'b0010, 4'b0000, 0, g, s, id, ov);
        nchk++;
        if (s !== 16'h8000) begin
            nerr++;
            $display("FAIL wrap_7fff: sum=%h expected 8000", s);
        end
`ifdef ADD16_ARB_OVF_EN
        nchk++;
        if (ov !== 1'b1) begin
            nerr++;
            $display("FAIL wrap_ovf: ovf=%b expected 1", ov);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [3:0] g; logic [15:0] s; logic [1:0] id; logic ov;
        a_op[0] = 16'h1234; b_op[0] = 16'h1111;
        a_op[2] = 16'h0100; b_op[2] = 16'h0020;
        run_txn(4'b0001, 4'b0100, 5, g, s, id, ov);
        nchk++;
        if (gnt !== 4'b0100) begin
            nerr++;
            $display("FAIL backpressure_next_gnt: gnt=%b expected 0100 in IDLE after release", gnt);
        end
        run_txn(4'b0100, 4'b0000, 0, g, s, id, ov);
        nchk++;
        if (g !== 4'b0100 || s !== 16'h0120 || id !== 2'd2) begin
            nerr++;
            $display("FAIL backpressure_txn: gnt=%b sum=%h id=%0d expected 0100 0120 2", g, s, id);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] g; logic [15:0] s; logic [1:0] id; logic ov;
        a_op[2] = 16'h5555; b_op[2] = 16'h1111;
        a_op[1] = 16'h0002; b_op[1] = 16'h0005;
        load_ops();
        req = 4'b0100;
        #1;
        nchk++;
        if (gnt !== 4'b0100) begin
            nerr++;
            $display("FAIL reset_mid_gnt: gnt=%b expected 0100", gnt);
        end
        @(negedge clk);
        rst = 1'b1; req = 4'b0000;
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nchk++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_mid_discard: valid=%b gnt=%b expected 0 0000", rsp_valid, gnt);
        end
        @(negedge clk); #1;
        nchk++;
        if (rsp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_late: valid=%b expected 0", rsp_valid);
        end
        m_ptr = 0;
        run_txn(4'b0110, 4'b0000, 0, g, s, id, ov);
        nchk++;
        if (g !== 4'b0010 || s !== 16'h0007) begin
            nerr++;
            $display("FAIL reset_mid_ptr: gnt=%b sum=%h expected 0010 0007", g, s);
        end
    endtask

    task automatic test_pointer_wrap();
        logic [3:0] g; logic [15:0] s; logic [1:0] id; logic ov;
        a_op[3] = 16'h0010; b_op[3] = 16'h0001;
        a_op[0] = 16'h0020; b_op[0] = 16'h0002;
        run_txn(4'b1000, 4'b0000, 0, g, s, id, ov);
        run_txn(4'b1001, 4'b0000, 0, g, s, id, ov);
        nchk++;
        if (g !== 4'b0001 || id !== 2'd0) begin
            nerr++;
            $display("FAIL pointer_wrap: gnt=%b id=%0d expected 0001 0", g, id);
        end
    endtask

    task automatic test_random();
        logic [3:0] g; logic [15:0] s; logic [1:0] id; logic ov;
        logic [3:0] rq;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                a_op[i] = 16'($urandom); b_op[i] = 16'($urandom);
            end
            rq = 4'($urandom_range(1, 15));
            run_txn(rq, ($urandom_range(0, 1) == 1) ? rq : 4'b0000,
                    int'($urandom_range(0, 3)), g, s, id, ov);
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_pointer_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_add16_arb

`default_nettype wire

// File: doc/add16_arb.md
ADD16_ARB -- requirements
Module: add16_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one ADD16; legal range 2..8.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  NREQ  per-requester add request, level.
REQ-006 a_in  input  NREQ x 16 (packed)  operand X per requester.
REQ-007 b_in  input  NREQ x 16 (packed)  operand Y per requester.
REQ-008 gnt  output  NREQ  one-hot acceptance pulse, one cycle.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_sum  output  16  registered X+Y.
REQ-012 rsp_id  output  $clog2(NREQ)  index of the requester owning rsp_sum.
REQ-013 rsp_ovf  output  1  signed overflow flag; present only with ADD16_ARB_OVF_EN.

Function
REQ-014 FSM states SHALL be IDLE, CALC and RESP; there is exactly one transaction in flight.
REQ-015 IDLE, req==0: stay in IDLE, gnt=0.
REQ-016 IDLE, req!=0: the winner SHALL be the first set bit at or after rr_ptr, searching upward modulo NREQ; in the same cycle gnt[winner]=1 (combinational), a_in/b_in[winner] and winner are registered into op_a/op_b/op_id, and the next state is CALC.
REQ-017 Requesters hold req and operands stable until they see their gnt; req may stay high after gnt to request again.
REQ-018 CALC: ADD16 is driven from op_a/op_b; its s is registered into rsp_sum, op_id into rsp_id; next state RESP.
REQ-019 RESP: rsp_valid=1 and rsp_sum/rsp_id/rsp_ovf SHALL remain stable until rsp_ready=1.
REQ-020 RESP with rsp_ready=1: go to IDLE and set rr_ptr=(op_id+1) mod NREQ; no grant is issued in this cycle.
REQ-021 Latency: gnt in cycle T, rsp_valid first high in T+2; minimum issue interval 3 cycles.
REQ-022 Arithmetic: rsp_sum=(X+Y) mod 2^16; the carry-out is discarded (0xFFFF+0x0001=0x0000).
REQ-023 Requests arriving in CALC/RESP are ignored until IDLE; gnt is never asserted outside IDLE.
REQ-024 Simultaneous requests SHALL be granted strictly round-robin; a persistently requesting line waits at most NREQ-1 grants.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, rr_ptr=0, op_a/op_b/op_id=0, rsp_sum=0, rsp_id=0, rsp_valid=0, rsp_ovf=0, gnt=0 during reset.
REQ-026 Reset mid-operation (CALC/RESP) SHALL discard the transaction without producing a response.

Configuration
REQ-027 Macro ADD16_ARB_OVF_EN defined: rsp_ovf port exists, registered in CALC as (op_a[15]==op_b[15]) && (s[15]!=op_a[15]).
REQ-028 Macro undefined: rsp_ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Package add16_arb_pkg SHALL hold the state enum (IDLE/CALC/RESP), the data width constant (16) and the default NREQ constant.
REQ-030 Exactly one sub-module: the existing ADD16 instance (ports s, X, Y); arbitration and the FSM are inline.

Verification
REQ-031 Single request: req=0001, a=0x0003, b=0x0004 -> gnt=0001 at T, rsp_valid at T+2, rsp_sum=0x0007, rsp_id=0.
REQ-032 Contention: req=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, each rsp_id matching its grant.
REQ-033 Wrap-around: a=0xFFFF, b=0x0001 -> rsp_sum=0x0000; with OVF_EN, rsp_ovf=0. With a=0x7FFF, b=0x0001 -> rsp_sum=0x8000, rsp_ovf=1.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_sum stable, gnt=0 throughout, new req=0100 granted only in the cycle after rsp_ready=1 (IDLE).
REQ-035 Reset in CALC after granting requester 2 -> next cycle rsp_valid=0, rr_ptr=0; pending req=0110 then grants requester 1.
REQ-036 Pointer wrap: last grant to 3, req=1001 -> next grant goes to 0.
